ripple_carry_counter4: RTL and testbench



---
 rtl/ripple_carry_counter4.sv | 36 +++
 tb/tb_ripple_carry_counter4.sv | 94 +++++++++
 2 files changed

// File: rtl/ripple_carry_counter4.sv
// Free-running 4-bit up-counter built from four T-type stages with a rippled
// toggle-enable chain; advances on the falling edge of clk and wraps modulo 16.
module ripple_carry_counter4 (
    output logic [3:0] q,
    input  logic       clk,
    input  logic       reset
);

    logic [3:0] q_r;
    logic       t0_s;
    logic       t1_s;
    logic       t2_s;
    logic       t3_s;
    logic [3:0] d_s;

    // Toggle enables ripple LSB to MSB: a stage toggles when all lower stages are 1.
    always_comb begin
        t0_s = 1'b1;
        t1_s = t0_s & q_r[0];
        t2_s = t1_s & q_r[1];
        t3_s = t2_s & q_r[2];
        d_s  = q_r ^ {t3_s, t2_s, t1_s, t0_s};
    end

    // Stage flops share the falling edge; synchronous reset wins over counting.
    always_ff @(negedge clk) begin
        if (reset) begin
            q_r <= 4'd0;
        end else begin
            q_r <= d_s;
        end
    end

    assign q = q_r;

endmodule

// File: tb/tb_ripple_carry_counter4.sv
// Scoreboard bench for ripple_carry_counter4: a driver pushes the hand-computed
// count expected after each falling edge; a monitor pops and checks mid-cycle.
module tb_ripple_carry_counter4;

    logic       clk;
    logic       reset;
    logic [3:0] q;

    int checks = 0;
    int errors = 0;

    logic [3:0] sb_q[$];

    // Expected q after the falling edges at t = 10, 20, ..., 320.
    logic [3:0] exp_tbl [0:31] = '{
        4'd0,  4'd1,  4'd2,  4'd3,  4'd4,  4'd5,  4'd6,  4'd7,
        4'd8,  4'd9,  4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15,
        4'd0,  4'd1,  4'd2,  4'd0,  4'd1,  4'd2,  4'd3,  4'd4,
        4'd0,  4'd0,  4'd0,  4'd0,  4'd0,  4'd1,  4'd2,  4'd3
    };

    ripple_carry_counter4 dut (
        .q     (q),
        .clk   (clk),
        .reset (reset)
    );

    // Low 0-5, high 5-10: falling edges land on multiples of 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reset waveform: power-up, mid-count, between-edges pulse, held across 5 edges.
    initial begin
        reset = 1'b1;
        #15 reset = 1'b0;
        #180 reset = 1'b1;
        #10 reset = 1'b0;
        #27 reset = 1'b1;
        #5 reset = 1'b0;
        #8 reset = 1'b1;
        #50 reset = 1'b0;
    end

    // Push the expected response for each falling edge.
    initial begin
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            sb_q.push_back(exp_tbl[k]);
        end
    end

    // Pop at the rising edge, and check again just before the next falling edge.
    initial begin
        logic [3:0] exp_v;
        int         wait_cyc;
        for (int n = 0; n < 32; n++) begin
            @(posedge clk);
            wait_cyc = 0;
            while (sb_q.size() == 0 && wait_cyc < 5) begin
                @(posedge clk);
                wait_cyc++;
            end
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_timeout item=%0d: got no expected entry, required one", n);
            end else begin
                exp_v = sb_q.pop_front();
                if (q !== exp_v) begin
                    errors++;
                    $display("FAIL count_mid item=%0d t=%0t: q=%0d required %0d", n, $time, q, exp_v);
                end
                #4;
                checks++;
                if (q !== exp_v) begin
                    errors++;
                    $display("FAIL count_hold item=%0d t=%0t: q=%0d required %0d", n, $time, q, exp_v);
                end
            end
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #5000;
        $display("FAIL watchdog: simulation reached t=%0t, required completion before 5000", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
